// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, master indices and widths
// for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = 4;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select for two requesters,
// round-robin on last grant or fixed master-0 priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      (req == 2'b01): win = onehot(M0);
      (req == 2'b10): win = onehot(M1);
      (req == 2'b11): begin
        // contention: the master not served last goes next
        win = fixed_prio ? onehot(M0)
                         : onehot(~last);
      end
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two masters share one single-port memory through
// a three-state IDLE/ACCESS/DONE transaction FSM.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [BW-1:0] m0_we,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [BW-1:0] m1_we,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] wdata,
  output logic [AW-1:0] addr,
  output logic          re,
  output logic [BW-1:0] we,
  output logic [1:0]    grant
);

  state_t        state;
  state_t        state_n;
  logic [1:0]    own;
  logic          last;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [BW-1:0] we_q;
  logic [1:0]    win;
  logic          load;

  arb_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last       (last),
    .fixed_prio (FIXED_PRIO != 0),
    .win        (win)
  );

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    re       = 1'b0;
    we       = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    unique case (state)
      IDLE: begin
        if (|win) begin
          load    = 1'b1;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        re      = (we_q == '0);
        we      = we_q;
        state_n = DONE;
      end
      DONE: begin
        // memory data is passed straight through to the owner
        m0_ready = own[M0];
        m1_ready = own[M1];
        m0_rdata = own[M0] ? rdata : '0;
        m1_rdata = own[M1] ? rdata : '0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      own     <= '0;
      last    <= M1;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        own     <= win;
        last    <= win[1];
        addr_q  <= win[1] ? m1_addr : m0_addr;
        wdata_q <= win[1] ? m1_wdata : m0_wdata;
        we_q    <= win[1] ? m1_we : m0_we;
      end else if (state == DONE) begin
        own <= '0;
      end
    end
  end

  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign grant = own;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, ready scoreboard and corner
// sequences for round-robin and fixed-priority builds.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_we, m1_we;

  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] rdata, wdata;
  logic [29:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [1:0]  grant;

  logic        f_m0_ready, f_m1_ready;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic [31:0] f_rdata, f_wdata;
  logic [29:0] f_addr;
  logic        f_re;
  logic [3:0]  f_we;
  logic [1:0]  f_grant;

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRIO(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_we    (m0_we),
    .m0_ready (m0_ready),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_we    (m1_we),
    .m1_ready (m1_ready),
    .m1_rdata (m1_rdata),
    .rdata    (rdata),
    .wdata    (wdata),
    .addr     (addr),
    .re       (re),
    .we       (we),
    .grant    (grant)
  );

  mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_we    (m0_we),
    .m0_ready (f_m0_ready),
    .m0_rdata (f_m0_rdata),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_we    (m1_we),
    .m1_ready (f_m1_ready),
    .m1_rdata (f_m1_rdata),
    .rdata    (f_rdata),
    .wdata    (f_wdata),
    .addr     (f_addr),
    .re       (f_re),
    .we       (f_we),
    .grant    (f_grant)
  );

  function automatic logic [31:0] mem_fn(input logic [29:0] a);
    if (a == 30'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_1234;
  endfunction

  // memory answers one cycle after re
  always @(posedge clk) begin
    rdata   <= re ? mem_fn(addr) : 32'h0;
    f_rdata <= f_re ? mem_fn(f_addr) : 32'h0;
  end

  typedef struct {
    logic        own;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        r0, r1;
    logic [29:0] a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  w0, w1;
    logic [1:0]  g;
    logic [29:0] ea;
    logic [31:0] ed;
    logic [3:0]  ewe;
    logic        ere;
  } vec_t;

  exp_t sb[$];
  vec_t vt[8];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   prev_rdy = -1;
  bit   mon_on = 1'b0;
  bit   sel_fp = 1'b0;
  bit   chk_gap = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic own,
                          input logic [29:0] a,
                          input logic [3:0] w);
    exp_t e;
    e.own  = own;
    e.rd   = (w == 4'h0);
    e.data = mem_fn(a);
    sb.push_back(e);
  endtask

  task automatic monitor();
    logic        r0, r1, s_re;
    logic [3:0]  s_we;
    logic [31:0] d0, d1;
    exp_t        e;
    if (!mon_on) return;
    if (!chk_gap) prev_rdy = -1;
    r0   = sel_fp ? f_m0_ready : m0_ready;
    r1   = sel_fp ? f_m1_ready : m1_ready;
    d0   = sel_fp ? f_m0_rdata : m0_rdata;
    d1   = sel_fp ? f_m1_rdata : m1_rdata;
    s_re = sel_fp ? f_re : re;
    s_we = sel_fp ? f_we : we;
    chk("re_we_excl", {31'b0, s_re & (|s_we)}, 32'd0);
    if (r0 | r1) begin
      if (sb.size() == 0) begin
        chk("unexp_ready", {30'b0, r1, r0}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_ready", {30'b0, r1, r0}, e.own ? 2 : 1);
        if (e.rd) chk("sb_rdata", e.own ? d1 : d0, e.data);
        chk("sb_other_rdata", e.own ? d0 : d1, 32'd0);
        if (chk_gap && prev_rdy >= 0)
          chk("ready_gap", cyc - prev_rdy, 3);
        prev_rdy = cyc;
      end
    end
  endtask

  // monitor the current cycle, then advance past the next edge
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_vec(input vec_t v);
    m0_req = v.r0; m1_req = v.r1;
    m0_addr = v.a0; m1_addr = v.a1;
    m0_wdata = v.d0; m1_wdata = v.d1;
    m0_we = v.w0; m1_we = v.w1;
    step();
    chk("acc_grant", grant, v.g);
    chk("acc_re", re, v.ere);
    chk("acc_we", we, v.ewe);
    chk("acc_addr", addr, v.ea);
    chk("acc_wdata", wdata, v.ed);
    push_exp(v.g[1], v.ea, v.ewe);
    m0_req = 0; m1_req = 0;
    m0_addr = ~m0_addr; m1_addr = ~m1_addr;
    m0_wdata = ~m0_wdata; m1_wdata = ~m1_wdata;
    m0_we = 4'hF; m1_we = 4'hF;
    step();
    chk("done_grant", grant, v.g);
    chk("done_re", re, 0);
    chk("done_we", we, 0);
    chk("done_addr", addr, v.ea);
    chk("done_wdata", wdata, v.ed);
    step();
    chk("idle_grant", grant, 0);
    chk("idle_addr", addr, v.ea);
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 30'h10, 30'h0,
              32'h11111111, 32'h0, 4'h0, 4'h0,
              2'b01, 30'h10, 32'h11111111, 4'h0, 1'b1};
    vt[1] = '{1'b0, 1'b1, 30'h0, 30'h3FFFFFFF,
              32'h0, 32'h12345678, 4'h0, 4'h3,
              2'b10, 30'h3FFFFFFF, 32'h12345678, 4'h3, 1'b0};
    vt[2] = '{1'b1, 1'b1, 30'h100, 30'h200,
              32'h22222222, 32'hCAFEF00D, 4'h0, 4'hF,
              2'b01, 30'h100, 32'h22222222, 4'h0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 30'h100, 30'h200,
              32'h22222222, 32'hCAFEF00D, 4'h0, 4'hF,
              2'b10, 30'h200, 32'hCAFEF00D, 4'hF, 1'b0};
    vt[4] = '{1'b0, 1'b1, 30'h77, 30'h55,
              32'h0, 32'h33333333, 4'h0, 4'h0,
              2'b10, 30'h55, 32'h33333333, 4'h0, 1'b1};
    vt[5] = '{1'b1, 1'b1, 30'h3, 30'h66,
              32'hA5A5A5A5, 32'h0, 4'h4, 4'h0,
              2'b01, 30'h3, 32'hA5A5A5A5, 4'h4, 1'b0};
    vt[6] = '{1'b1, 1'b0, 30'h20, 30'h0,
              32'h44444444, 32'h0, 4'h0, 4'h0,
              2'b01, 30'h20, 32'h44444444, 4'h0, 1'b1};
    vt[7] = '{1'b1, 1'b1, 30'h21, 30'h30,
              32'h5, 32'h66666666, 4'h0, 4'h0,
              2'b10, 30'h30, 32'h66666666, 4'h0, 1'b1};

    reset = 0;
    m0_req = 0; m1_req = 0;
    m0_addr = 0; m1_addr = 0;
    m0_wdata = 0; m1_wdata = 0;
    m0_we = 0; m1_we = 0;
    step();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_re", re, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ready", {m1_ready, m0_ready}, 0);
    chk("rst_fp_grant", f_grant, 0);
    chk("rst_fp_re", f_re, 0);
    mon_on = 1'b1;
    reset = 1;

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // round-robin contention, reqs held across transactions
    m0_req = 1; m1_req = 1;
    m0_addr = 30'h40; m1_addr = 30'h80;
    m0_we = 0; m1_we = 0;
    for (int k = 0; k < 4; k++) push_exp(k[0], k[0] ? 30'h80 : 30'h40, 4'h0);
    chk_gap = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_grant", grant, k[0] ? 2'b10 : 2'b01);
      step();
      chk("rr_ready", {m1_ready, m0_ready}, k[0] ? 2'b10 : 2'b01);
      step();
      chk("rr_idle", grant, 0);
      if (k == 3) begin
        m0_req = 0; m1_req = 0;
      end
    end
    chk_gap = 1'b0;
    step();
    chk("rr_stay_idle", grant, 0);

    // m1 drops req during ACCESS
    m1_req = 1; m1_addr = 30'h99;
    m1_wdata = 32'h77777777; m1_we = 4'hF;
    step();
    chk("drop_grant", grant, 2'b10);
    push_exp(1'b1, 30'h99, 4'hF);
    m1_req = 0;
    step();
    chk("drop_ready", {m1_ready, m0_ready}, 2'b10);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("drop_no_grant", grant, 0);
      chk("drop_no_re", re, 0);
    end

    // reset during ACCESS of an m0 read
    m0_req = 1; m0_addr = 30'h123; m0_we = 0;
    step();
    chk("rst_mid_acc", {re, grant}, 3'b101);
    reset = 0; m1_req = 1;
    step();
    chk("rst_mid_re", re, 0);
    chk("rst_mid_we", we, 0);
    chk("rst_mid_grant", grant, 0);
    chk("rst_mid_ready", {m1_ready, m0_ready}, 0);
    chk("rst_mid_addr", addr, 0);
    reset = 1;
    step();
    chk("rst_after_grant", grant, 2'b01);
    push_exp(1'b0, 30'h123, 4'h0);
    m0_req = 0; m1_req = 0;
    step();
    step();
    chk("rst_after_idle", grant, 0);

    // fixed priority build
    sel_fp = 1'b1;
    m0_req = 1; m1_req = 1;
    m0_addr = 30'h200; m1_addr = 30'h300;
    m0_we = 0; m1_we = 0;
    for (int k = 0; k < 3; k++) push_exp(1'b0, 30'h200, 4'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fp_grant", f_grant, 2'b01);
      step();
      chk("fp_ready", {f_m1_ready, f_m0_ready}, 2'b01);
      step();
      chk("fp_idle", f_grant, 0);
      if (k == 2) m0_req = 0;
    end
    step();
    chk("fp_m1_grant", f_grant, 2'b10);
    push_exp(1'b1, 30'h300, 4'h0);
    m1_req = 0;
    step();
    chk("fp_m1_ready", {f_m1_ready, f_m0_ready}, 2'b10);
    step();
    chk("fp_end_idle", f_grant, 0);

    step();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
